// File: rtl/dmem_access_unit_pkg.sv
// Memory access-size encodings and data memory defaults shared
// by the control path and the data memory.
package dmem_access_unit_pkg;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   localparam logic [31:0] DATA_BASE_DEFAULT = 32'h0000_0000;

   localparam int DMEM_WORDS = 128;
   localparam int DMEM_AW    = 7;

endpackage

// File: rtl/dmem_access_unit_ext.sv
// width_ext: widen an N-bit load value to 32 bits,
// sign- or zero-extended.
module width_ext #(
   parameter int N = 8
) (
   input  logic [N-1:0] val,
   input  logic         sext,
   output logic [31:0]  ext
);

   assign ext = {{(32-N){sext & val[N-1]}}, val};

endmodule

// File: rtl/dmem_access_unit.sv
// Data memory: 128x32 little-endian array with combinational
// sized reads and byte/half/word merged writes.
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter logic [31:0] DATA_BASE_ADDRESS = DATA_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DMWr,
   input  logic [1:0]  MemOp,
   input  logic        MemEXT,
   input  logic [31:0] address,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   logic [31:0]        mem [DMEM_WORDS];
   logic [31:0]        offset;
   logic [DMEM_AW-1:0] idx;
   logic [1:0]         lane;
   logic [31:0]        word;
   logic [7:0]         rd_byte;
   logic [15:0]        rd_half;
   logic [31:0]        byte_ext;
   logic [31:0]        half_ext;
   logic [31:0]        wdata;
   logic               we;

   assign offset  = address - DATA_BASE_ADDRESS;
   assign idx     = offset[8:2];
   assign lane    = offset[1:0];
   assign word    = mem[idx];
   assign rd_byte = word[{lane, 3'b000} +: 8];
   assign rd_half = lane[1] ? word[31:16] : word[15:0];

   width_ext #(.N(8)) u_ext_b (
      .val  (rd_byte),
      .sext (MemEXT),
      .ext  (byte_ext)
   );

   width_ext #(.N(16)) u_ext_h (
      .val  (rd_half),
      .sext (MemEXT),
      .ext  (half_ext)
   );

   always_comb begin
      dout = word;
      case (MemOp)
         MEM_BYTE: dout = byte_ext;
         MEM_HALF: dout = half_ext;
         default:  dout = word;
      endcase
   end

   // misaligned half stores are dropped, not split
   always_comb begin
      wdata = word;
      we    = DMWr;
      case (MemOp)
         MEM_BYTE: wdata[{lane, 3'b000} +: 8] = din[7:0];
         MEM_HALF: begin
            if (lane[0])
               we = 1'b0;
            else if (lane[1])
               wdata[31:16] = din[15:0];
            else
               wdata[15:0] = din[15:0];
         end
         default: wdata = din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DMEM_WORDS; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit against a
// byte-addressed reference memory.
module tb_dmem_access_unit;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk;
   logic        rst;
   logic        DMWr;
   logic [1:0]  MemOp;
   logic        MemEXT;
   logic [31:0] address;
   logic [31:0] din;
   logic [31:0] dout;

   int checks;
   int errors;
   bit chk_en;

   logic [7:0] mb [512];

   dmem_access_unit #(.DATA_BASE_ADDRESS(BASE)) dut (
      .clk     (clk),
      .rst     (rst),
      .DMWr    (DMWr),
      .MemOp   (MemOp),
      .MemEXT  (MemEXT),
      .address (address),
      .din     (din),
      .dout    (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int boff(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return int'(o[8:0]);
   endfunction

   function automatic logic [31:0] model_rd(
      input logic [31:0] a, input logic [1:0] op, input logic sx);
      int b, wb, hb;
      logic [31:0] r;
      b  = boff(a);
      wb = b & ~3;
      hb = wb + ((b & 2) != 0 ? 2 : 0);
      if (op == 2'd0) begin
         r = {24'h0, mb[b]};
         if (sx && mb[b][7]) r[31:8] = '1;
      end else if (op == 2'd1) begin
         r = {16'h0, mb[hb+1], mb[hb]};
         if (sx && mb[hb+1][7]) r[31:16] = '1;
      end else begin
         r = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
      end
      return r;
   endfunction

   always @(posedge clk) begin
      int b, wb, hb;
      b  = boff(address);
      wb = b & ~3;
      hb = wb + ((b & 2) != 0 ? 2 : 0);
      if (rst) begin
         foreach (mb[i]) mb[i] = 8'h00;
         chk_en = 1'b1;
      end else if (DMWr) begin
         if (MemOp == 2'd0) begin
            mb[b] = din[7:0];
         end else if (MemOp == 2'd1) begin
            if ((b & 1) == 0) begin
               mb[hb]   = din[7:0];
               mb[hb+1] = din[15:8];
            end
         end else begin
            for (int k = 0; k < 4; k++)
               mb[wb+k] = din[8*k +: 8];
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] exp;
      if (chk_en) begin
         exp = model_rd(address, MemOp, MemEXT);
         checks++;
         if (dout !== exp) begin
            errors++;
            $display("FAIL model a=%h op=%0d x=%0b got %h want %h",
                     address, MemOp, MemEXT, dout, exp);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] off, input logic [1:0] op,
                     input logic [31:0] d);
      rst = 1'b0; DMWr = 1'b1; MemOp = op; MemEXT = 1'b0;
      address = BASE + off; din = d;
      cyc();
      DMWr = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [31:0] off,
                     input logic [1:0] op, input logic sx,
                     input logic [31:0] exp);
      rst = 1'b0; DMWr = 1'b0; MemOp = op; MemEXT = sx;
      address = BASE + off; din = 32'h0;
      @(negedge clk);
      #1;
      checks++;
      if (dout !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, dout, exp);
      end
      cyc();
   endtask

   initial begin
      checks = 0; errors = 0; chk_en = 1'b0;
      rst = 1'b1; DMWr = 1'b1; MemOp = 2'd2; MemEXT = 1'b0;
      address = BASE; din = 32'hFFFF_FFFF;
      cyc();
      cyc();
      rd("rst_w0", 32'h000, 2'd2, 1'b0, 32'h0);
      rd("rst_b3x", 32'h003, 2'd0, 1'b1, 32'h0);
      rd("rst_h1fe", 32'h1FE, 2'd1, 1'b1, 32'h0);

      wr(32'h0, 2'd2, 32'h1234_5678);
      rd("w0", 32'h0, 2'd2, 1'b0, 32'h1234_5678);
      rd("b0", 32'h0, 2'd0, 1'b0, 32'h78);
      rd("b1", 32'h1, 2'd0, 1'b0, 32'h56);
      rd("b2", 32'h2, 2'd0, 1'b0, 32'h34);
      rd("b3", 32'h3, 2'd0, 1'b0, 32'h12);
      rd("op3", 32'h1, 2'd3, 1'b1, 32'h1234_5678);

      wr(32'h4, 2'd2, 32'h0);
      wr(32'h6, 2'd0, 32'hFFFF_FFAB);
      rd("bw_word", 32'h4, 2'd2, 1'b0, 32'h00AB_0000);
      rd("b6_sx", 32'h6, 2'd0, 1'b1, 32'hFFFF_FFAB);
      rd("b6_zx", 32'h6, 2'd0, 1'b0, 32'h0000_00AB);

      wr(32'h8, 2'd2, 32'h1111_1111);
      wr(32'hA, 2'd1, 32'h0000_8001);
      rd("hw_word", 32'h8, 2'd2, 1'b0, 32'h8001_1111);
      rd("h10_sx", 32'hA, 2'd1, 1'b1, 32'hFFFF_8001);
      rd("h11_zx", 32'hB, 2'd1, 1'b0, 32'h0000_8001);
      wr(32'h9, 2'd1, 32'h0000_1234);
      rd("h_mis", 32'h8, 2'd2, 1'b0, 32'h8001_1111);

      wr(32'h1F8, 2'd2, 32'h0BAD_F00D);
      wr(32'h1FC, 2'd2, 32'hDEAD_BEEF);
      rd("alias", 32'h3FC, 2'd2, 1'b0, 32'hDEAD_BEEF);
      rd("nbr", 32'h1F8, 2'd2, 1'b0, 32'h0BAD_F00D);

      wr(32'h20, 2'd0, 32'h11);
      wr(32'h21, 2'd0, 32'h22);
      wr(32'h22, 2'd1, 32'h4433);
      rd("b2b", 32'h20, 2'd2, 1'b0, 32'h4433_2211);

      rst = 1'b0; DMWr = 1'b1; MemOp = 2'd2; MemEXT = 1'b0;
      address = BASE + 32'h20; din = 32'h9999_9999;
      @(negedge clk);
      #1;
      checks++;
      if (dout !== 32'h4433_2211) begin
         errors++;
         $display("FAIL rdw_old got %h want %h", dout, 32'h4433_2211);
      end
      cyc();
      DMWr = 1'b0;
      rd("rdw_new", 32'h20, 2'd2, 1'b0, 32'h9999_9999);

      wr(32'h30, 2'd0, 32'h77);
      rst = 1'b1; DMWr = 1'b0;
      cyc();
      wr(32'h31, 2'd0, 32'h66);
      rd("rst_mid", 32'h30, 2'd2, 1'b0, 32'h0000_6600);

      rst = 1'b1; DMWr = 1'b1; MemOp = 2'd2;
      address = BASE + 32'h40; din = 32'h5555_5555;
      cyc();
      rst = 1'b0; DMWr = 1'b0;
      rd("rst_wr", 32'h40, 2'd2, 1'b0, 32'h0);
      rd("rst_clr0", 32'h0, 2'd2, 1'b0, 32'h0);
      rd("rst_clr1fc", 32'h1FC, 2'd2, 1'b0, 32'h0);
      rd("rst_clr20", 32'h20, 2'd0, 1'b1, 32'h0);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_BASE_ADDRESS, default 32'h0000_0000, giving the byte address of data word 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port DMWr, input, 1 bit: 1 = write this cycle, 0 = read only.
REQ-005 The block SHALL have port MemOp, input, 2 bits: access size; 2'd0 byte, 2'd1 half, 2'd2 word, 2'd3 treated as word.
REQ-006 The block SHALL have port MemEXT, input, 1 bit: 1 = sign-extend byte/half reads, 0 = zero-extend.
REQ-007 The block SHALL have port address, input, 32 bits: byte address of the access.
REQ-008 The block SHALL have port din, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 The block SHALL have port dout, output, 32 bits: load data, extended to 32 bits.

Function
REQ-010 Storage SHALL be 128 words x 32 bits; offset = address - DATA_BASE_ADDRESS (32-bit wrap); word index = offset[8:2]; offset bits above [8] are ignored, so addresses alias modulo 512 bytes.
REQ-011 Byte lane numbering SHALL be little-endian: lane k = word bits [8k+7:8k], k = offset[1:0].
REQ-012 Reads SHALL be combinational (zero latency); dout SHALL follow address, MemOp and MemEXT in the same cycle, regardless of DMWr.
REQ-013 Byte read: the lane selected by offset[1:0], extended per MemEXT (sign bit = bit 7).
REQ-014 Half read: offset[1]=0 selects bits [15:0], offset[1]=1 selects bits [31:16], extended per MemEXT (sign bit = bit 15); offset[0] is ignored.
REQ-015 Word read: the full word; offset[1:0] ignored; MemEXT ignored.
REQ-016 Byte write (DMWr=1): on the rising edge, lane offset[1:0] SHALL take din[7:0]; the other three lanes are unchanged.
REQ-017 Half write: offset[1:0]=0 SHALL write din[15:0] to [15:0], offset[1:0]=2 SHALL write it to [31:16], other bits unchanged; offset[0]=1 (misaligned) SHALL suppress the write, leaving memory unchanged.
REQ-018 Word write: the entire word SHALL take din; offset[1:0] ignored.
REQ-019 Read-during-write: dout SHALL show the old word contents until the write edge, and the new contents after it.
REQ-020 Back-to-back writes to the same word on consecutive cycles SHALL both take effect in order, each merging into the result of the previous one.

Reset
REQ-021 When rst=1 at a rising edge, all 128 words SHALL be cleared to 32'h0000_0000, and any write that cycle SHALL be ignored.
REQ-022 After reset, dout SHALL read 32'h0000_0000 for every address, size and MemEXT setting.
REQ-023 A reset asserted between two partial writes to the same word SHALL discard the earlier write completely.

Structure
REQ-024 MemOp encodings (MEM_BYTE, MEM_HALF, MEM_WORD) and the default DATA_BASE_ADDRESS SHALL live in the shared control-encoding package.
REQ-025 One sub-module SHALL be used: width_ext, parameterized by input width N, mapping an N-bit value plus an extend-op bit to 32 bits; it is instantiated once for N=8 and once for N=16.
REQ-026 Lane merge for writes and lane select for reads SHALL be combinational logic in the top module; the storage array is the only sequential element.

Verification
REQ-027 Reset, then word write 0x12345678 at offset 0; word read -> 0x12345678; byte reads at offsets 0..3 (MemEXT=0) -> 0x78, 0x56, 0x34, 0x12.
REQ-028 Word 0x0000_0000 at offset 4; byte write 0xAB at offset 6 -> word 0x00AB_0000; byte read at offset 6 with MemEXT=1 -> 0xFFFF_FFAB, with MemEXT=0 -> 0x0000_00AB.
REQ-029 Half write 0x8001 at offset 10 over word 0x1111_1111 -> word 0x8001_1111; half read at offset 10 with MemEXT=1 -> 0xFFFF_8001; half write at offset 9 -> memory unchanged.
REQ-030 Word write 0xDEADBEEF to offset 0x1FC, then word read at offset 0x3FC -> 0xDEADBEEF (aliasing); read at offset 0x1F8 -> unaffected.
REQ-031 Word write with rst=1 in the same cycle -> word stays 0; nonzero contents followed by rst -> all words read 0.
